wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master, one-slave Wishbone arbiter placed directly upstream of the SRAM slave on the system bus. It merges the instruction-fetch port (m0) and the data port (m1) of the core onto the single slave port that drives the RAM controller. Arbitration is round-robin, and grant is held for a whole bus cycle (cyc). Slave response signals are routed back only to the current owner.

## Interface
Parameters:
- TIMEOUT, 255: number of cycles to wait for ack/err/rty before the watchdog fires. Used only with the watchdog compiled in; legal range 2..65535.

Ports (mN = m0 or m1; each mN line is one port per master):
- clk_bus  input  1  bus clock; all logic is on the rising edge.
- rst_bus  input  1  synchronous, active-high reset.
- mN_cyc_i  input  1  master N requests the bus or holds its cycle.
- mN_stb_i  input  1  master N strobe.
- mN_we_i  input  1  master N write enable.
- mN_sel_i  input  4  master N byte selects.
- mN_adr_i  input  32  master N byte address.
- mN_dat_i  input  32  master N write data.
- mN_dat_o  output  32  read data; s_dat_i broadcast to both masters.
- mN_ack_o, mN_err_o, mN_rty_o  output  1 each  response, given to the owner only.
- s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side control.
- s_sel_o  output  4  slave byte selects.
- s_adr_o  output  32  slave address.
- s_dat_o  output  32  slave write data.
- s_dat_i  input  32  slave read data.
- s_ack_i, s_err_i, s_rty_i  input  1 each  slave response.
- gnt_o  output  2  one-hot grant {m1,m0}; 2'b00 when idle.

## Operation
- State machine: IDLE, OWN0, OWN1. Register `last` holds the most recent owner.
- IDLE:
  - Only m0_cyc_i high → OWN0. Only m1_cyc_i high → OWN1.
  - Both high → grant the master that is not `last`.
  - All s_* control outputs are 0 and gnt_o = 00.
- OWNn:
  - s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o are combinational copies of master n's inputs.
  - s_ack_i, s_err_i and s_rty_i pass combinationally to mn_*_o.
  - The other master's ack, err and rty outputs are forced to 0.
- Leaving OWNn: when mn_cyc_i is low, go to IDLE and set `last` = n. Block and RMW cycles, where cyc stays high across several strobes, are never split.
- A request from the other master during OWNn waits. It is not dropped and not acknowledged.
- Reset values: state IDLE, `last` = 1 (so m0 wins the first tie), every s_* output 0, every mN_ack/err/rty 0, gnt_o 00. mN_dat_o follows s_dat_i and has no reset value.
- Reset asserted mid-cycle: the arbiter returns to IDLE on the next edge and the slave sees s_cyc_o drop.

## Timing
- Grant latency is 1 cycle: cyc_i is sampled high in IDLE, and s_cyc_o is asserted on the following cycle.
- Slave-to-master response path is purely combinational, zero added latency.
- Release latency is 1 cycle: owner drops cyc_i at edge k, state is IDLE after edge k.
- Minimum turnaround between back-to-back owners is 1 IDLE cycle.
- The arbiter does not alter stb/ack pairing: single-cycle or multi-cycle slave acks pass through unchanged.

## Configuration
- WB_ARB_WATCHDOG_EN defined:
  - A $clog2(TIMEOUT+1)-bit counter clears on entry to OWNn and whenever any of s_ack_i, s_err_i or s_rty_i is high.
  - It increments each cycle that s_stb_o is high with no response.
  - When it reaches TIMEOUT, the owner's err_o is pulsed for exactly 1 cycle, s_stb_o is forced low for that cycle, and the counter clears.
  - Ownership is still released only by cyc_i falling.
- WB_ARB_WATCHDOG_EN undefined: no counter exists, and a stalled slave blocks the bus indefinitely.

## Test plan
- Single master, no contention: m0 reads 0x0000_0010 and the slave acks after 2 cycles with 0xDEADBEEF → s_cyc_o rises 1 cycle after m0_cyc_i, m0_dat_o = 0xDEADBEEF, m0_ack_o high for 1 cycle, m1_ack_o stays 0.
- Simultaneous request after reset: m0 and m1 raise cyc in the same cycle → gnt_o = 01. After m0 drops cyc, 1 IDLE cycle follows, then gnt_o = 10.
- Round-robin fairness: both masters request continuously, each issuing 1-strobe cycles → grants alternate 01,10,01,10 with exactly one idle cycle between them.
- Block cycle hold: m1 keeps cyc high over 4 strobes with sel 4'b0011, and m0 requests midway → m0 is not granted until m1 drops cyc; s_sel_o = 0011 for all 4 strobes.
- Reset mid-cycle: rst_bus is asserted for 1 cycle during OWN0 → the next cycle has s_cyc_o = 0 and gnt_o = 00, and the first tie after reset goes to m0.
- Watchdog (macro defined, TIMEOUT = 4): the slave never acks → m0_err_o pulses exactly on the 4th stalled cycle and s_stb_o is low that cycle. With the macro undefined, err never asserts.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone round-robin arbiter; grant held for a whole cyc.
// Optional response watchdog compiled in with `define WB_ARB_WATCHDOG_EN.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_bus,
    input  logic        rst_bus,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  gnt_o
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

    logic [1:0] state, state_nxt;
    logic       last, last_nxt;
    logic       stb_raw;
    logic       wd_fire;
    logic       own0, own1;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) state_nxt = OWN0;
                else if (m1_cyc_i)                   state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_bus) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst_bus) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            stb_raw = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            stb_raw = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // A watchdog abort replaces the stalled strobe with a synthetic error.
    assign s_stb_o  = stb_raw & ~wd_fire;
    assign gnt_o    = state;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = own0 & s_ack_i;
    assign m0_err_o = own0 & (s_err_i | wd_fire);
    assign m0_rty_o = own0 & s_rty_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m1_err_o = own1 & (s_err_i | wd_fire);
    assign m1_rty_o = own1 & s_rty_i;

`ifdef WB_ARB_WATCHDOG_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;
    logic          any_rsp;

    assign any_rsp = s_ack_i | s_err_i | s_rty_i;
    // Fires on the cycle that would bring the stalled-strobe count up to TIMEOUT.
    assign wd_fire = stb_raw && !any_rsp && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_bus) begin
        if (rst_bus || (state == IDLE) || any_rsp || wd_fire) wd_cnt <= '0;
        else if (stb_raw)                                     wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic unused_timeout;

    assign wd_fire        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios then random traffic,
// all compared every cycle against a transaction-level ownership model.
module tb_wb_arbiter_2m;

    localparam int TO = 4;
`ifdef WB_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk_bus = 1'b0;
    logic        rst_bus = 1'b1;
    logic [1:0]  cyc, stb, we;
    logic [3:0]  sel  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  gnt_o;

    wb_arbiter_2m #(.TIMEOUT(TO)) dut (
        .clk_bus(clk_bus), .rst_bus(rst_bus),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    always #5 clk_bus = ~clk_bus;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // and how many consecutive unanswered strobes the owner has issued.
    int owner      = -1;
    int last_owner = 1;
    int stall      = 0;

    function automatic bit any_rsp();
        return s_ack_i | s_err_i | s_rty_i;
    endfunction

    function automatic bit fire_now();
        return WD && (owner >= 0) && stb[owner] && !any_rsp() && (stall + 1 == TO);
    endfunction

    task automatic compare_all();
        bit         f;
        logic [1:0] eg;
        f  = fire_now();
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        check("gnt", gnt_o, eg);
        if (owner < 0) begin
            check("s_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, 0);
            check("s_adr", s_adr_o, 0);
            check("s_dat", s_dat_o, 0);
        end else begin
            check("s_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o},
                  {cyc[owner], stb[owner] & ~f, we[owner], sel[owner]});
            check("s_adr", s_adr_o, adr[owner]);
            check("s_dat", s_dat_o, wdat[owner]);
        end
        check("m0_rsp", {m0_ack_o, m0_err_o, m0_rty_o},
              (owner == 0) ? {s_ack_i, s_err_i | f, s_rty_i} : 3'b000);
        check("m1_rsp", {m1_ack_o, m1_err_o, m1_rty_o},
              (owner == 1) ? {s_ack_i, s_err_i | f, s_rty_i} : 3'b000);
        check("m_dat", {m1_dat_o, m0_dat_o}, {s_dat_i, s_dat_i});
    endtask

    task automatic model_edge();
        bit f;
        f = fire_now();
        if (rst_bus) begin
            owner = -1; last_owner = 1; stall = 0;
        end else if (owner < 0) begin
            stall = 0;
            if (cyc[0] && cyc[1]) owner = (last_owner == 0) ? 1 : 0;
            else if (cyc[0])      owner = 0;
            else if (cyc[1])      owner = 1;
        end else if (!cyc[owner]) begin
            last_owner = owner; owner = -1; stall = 0;
        end else if (any_rsp() || f) begin
            stall = 0;
        end else if (stb[owner]) begin
            stall++;
        end
    endtask

    task automatic step();
        #1 compare_all();
    endtask

    task automatic tick();
        @(posedge clk_bus);
        model_edge();
        @(negedge clk_bus);
    endtask

    task automatic cyc_once();
        step();
        tick();
    endtask

    task automatic idle_inputs();
        cyc = '0; stb = '0; we = '0;
        for (int m = 0; m < 2; m++) begin
            sel[m] = 4'hF; adr[m] = 32'h0; wdat[m] = 32'h0;
        end
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit [1:0] ackd;
        int       grants, idle_run;
        logic [1:0] cur;

        idle_inputs();
        rst_bus = 1'b1;
        @(negedge clk_bus);
        tick();
        tick();
        rst_bus = 1'b0;

        step();
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 0);
        tick();

        // Single read by m0, slave acks on the second owned cycle.
        cyc[0] = 1; stb[0] = 1; sel[0] = 4'hF; adr[0] = 32'h0000_0010;
        step(); check("A_not_yet", s_cyc_o, 0); tick();
        step(); check("A_s_cyc", s_cyc_o, 1); check("A_adr", s_adr_o, 32'h10); tick();
        s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
        step();
        check("A_dat", m0_dat_o, 32'hDEADBEEF);
        check("A_ack0", m0_ack_o, 1);
        check("A_ack1", m1_ack_o, 0);
        tick();
        s_ack_i = 0; cyc[0] = 0; stb[0] = 0;
        step(); check("A_ack_pulse", m0_ack_o, 0); tick();
        step(); check("A_idle", gnt_o, 2'b00); tick();

        // Tie straight after reset goes to m0, m1 follows after one idle cycle.
        rst_bus = 1; cyc_once(); rst_bus = 0;
        cyc = 2'b11; stb = 2'b11; adr[1] = 32'h0000_2000;
        step(); check("B_idle", gnt_o, 2'b00); tick();
        s_ack_i = 1;
        step(); check("B_tie", gnt_o, 2'b01); tick();
        s_ack_i = 0; cyc[0] = 0; stb[0] = 0;
        cyc_once();
        step(); check("B_turn", gnt_o, 2'b00); tick();
        s_ack_i = 1;
        step(); check("B_m1", gnt_o, 2'b10); tick();
        s_ack_i = 0; cyc[1] = 0; stb[1] = 0;
        cyc_once(); cyc_once();

        // Round robin: both masters keep requesting single-strobe cycles.
        ackd = 2'b00; grants = 0; idle_run = 0; cur = 2'b00;
        for (int t = 0; t < 24; t++) begin
            cyc = ~ackd; stb = ~ackd;
            #1 s_ack_i = (gnt_o == 2'b01 && stb[0]) || (gnt_o == 2'b10 && stb[1]);
            step();
            if (gnt_o == 2'b00) begin
                idle_run++;
            end else if (gnt_o != cur) begin
                check("C_order", gnt_o, (grants % 2 == 0) ? 2'b01 : 2'b10);
                if (grants > 0) check("C_gap", idle_run, 1);
                grants++; idle_run = 0; cur = gnt_o;
            end
            ackd = {s_ack_i & gnt_o[1], s_ack_i & gnt_o[0]};
            tick();
        end
        check("C_grants", grants >= 6, 1);
        idle_inputs();
        cyc_once(); cyc_once(); cyc_once();

        // Block cycle: m1 holds cyc over four strobes while m0 waits.
        cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'b0011; adr[1] = 32'h100;
        cyc_once();
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin cyc[0] = 1; stb[0] = 1; adr[0] = 32'h200; end
            adr[1] = 32'h100 + 32'(4 * k); wdat[1] = $urandom; s_ack_i = 1;
            step();
            check("D_sel", s_sel_o, 4'b0011);
            check("D_hold", gnt_o, 2'b10);
            tick();
        end
        s_ack_i = 0; cyc[1] = 0; stb[1] = 0;
        step(); check("D_still_m1", gnt_o, 2'b10); tick();
        step(); check("D_turn", gnt_o, 2'b00); tick();
        step(); check("D_m0", gnt_o, 2'b01); tick();
        idle_inputs();
        cyc_once(); cyc_once();

        // Reset during OWN0; the first tie afterwards goes to m0.
        cyc[0] = 1; stb[0] = 1;
        cyc_once();
        step(); check("E_own0", gnt_o, 2'b01); tick();
        rst_bus = 1; cyc_once(); rst_bus = 0;
        cyc[1] = 1; stb[1] = 1;
        step(); check("E_s_cyc", s_cyc_o, 0); check("E_gnt", gnt_o, 2'b00); tick();
        step(); check("E_tie", gnt_o, 2'b01); tick();
        idle_inputs();
        cyc_once(); cyc_once(); cyc_once();

        // Stalled slave: err pulses every TO stalled cycles only with the watchdog.
        cyc[0] = 1; stb[0] = 1; adr[0] = 32'h300;
        cyc_once();
        for (int k = 1; k <= 9; k++) begin
            step();
            check("F_err", m0_err_o, WD && (k % TO == 0));
            check("F_stb", s_stb_o, !(WD && (k % TO == 0)));
            check("F_hold", gnt_o, 2'b01);
            tick();
        end
        idle_inputs();
        cyc_once(); cyc_once();

        // Random traffic, including stray strobes, errors, retries and resets.
        for (int t = 0; t < 1500; t++) begin
            rst_bus = ($urandom_range(0, 199) == 0);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 3) == 0) cyc[m] = ~cyc[m];
                stb[m]  = cyc[m] ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) == 0);
                we[m]   = 1'($urandom_range(0, 1));
                sel[m]  = 4'($urandom);
                adr[m]  = $urandom;
                wdat[m] = $urandom;
            end
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(0, 2) == 0);
            s_err_i = ($urandom_range(0, 15) == 0);
            s_rty_i = ($urandom_range(0, 15) == 0);
            cyc_once();
        end
        rst_bus = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
